// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered MDU results,
// with a starvation limit and a pending-destination scoreboard for decode.
module rf_wb_arbiter #(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        pipe_we_i,
   input  logic [4:0]  pipe_rd_i,
   input  logic [31:0] pipe_wd_i,
   output logic        pipe_stall_o,
   input  logic        mdu_valid_i,
   input  logic [4:0]  mdu_rd_i,
   input  logic [31:0] mdu_wd_i,
   output logic        mdu_ready_o,
   input  logic        issue_valid_i,
   input  logic [4:0]  issue_rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   output logic        rs1_busy_o,
   output logic        rs2_busy_o,
   output logic        we3_o,
   output logic [4:0]  a3_o,
   output logic [31:0] wd3_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] LP_SMAX = SW'(STARVE_MAX);

   logic [AW:0]   r_wptr, r_rptr;
   logic [4:0]    r_mem_rd [DEPTH];
   logic [31:0]   r_mem_wd [DEPTH];
   logic [31:0]   r_pending;
   logic [SW-1:0] r_starve;

   logic          w_empty, w_full, w_push, w_pop, w_force;
   logic [4:0]    w_head_rd;
   logic [31:0]   w_head_wd;
   logic [31:0]   w_pend_nxt;

   assign w_empty   = (r_wptr == r_rptr);
   assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_head_rd = r_mem_rd[r_rptr[AW-1:0]];
   assign w_head_wd = r_mem_wd[r_rptr[AW-1:0]];

   // The MDU takes the port when the pipeline is idle or has starved it long enough.
   assign w_force = !w_empty && pipe_we_i && (r_starve == LP_SMAX);
   assign w_pop   = rst_ni && !w_empty && (!pipe_we_i || (r_starve == LP_SMAX));

   assign mdu_ready_o  = rst_ni && !w_full;
   assign w_push       = mdu_valid_i && mdu_ready_o;
   assign pipe_stall_o = rst_ni && w_force;
   assign rs1_busy_o   = rst_ni && r_pending[rs1_i];
   assign rs2_busy_o   = rst_ni && r_pending[rs2_i];

   always_comb begin
      we3_o = 1'b0;
      a3_o  = pipe_rd_i;
      wd3_o = pipe_wd_i;
      if (w_pop) begin
         a3_o  = w_head_rd;
         wd3_o = w_head_wd;
         we3_o = (w_head_rd != 5'd0);
      end else begin
         we3_o = rst_ni && pipe_we_i && (pipe_rd_i != 5'd0);
      end
   end

   // Clear on pop first so a same-cycle issue to that register keeps it pending.
   always_comb begin
      w_pend_nxt = r_pending;
      if (w_pop) w_pend_nxt[w_head_rd] = 1'b0;
      if (issue_valid_i) w_pend_nxt[issue_rd_i] = 1'b1;
      w_pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem_rd[r_wptr[AW-1:0]] <= mdu_rd_i;
         r_mem_wd[r_wptr[AW-1:0]] <= mdu_wd_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_pending <= '0;
         r_starve  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_pending <= w_pend_nxt;
         if (w_empty || w_pop)  r_starve <= '0;
         else if (pipe_we_i)    r_starve <= r_starve + 1'b1;
      end
   end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the write-port rules.
module tb_rf_wb_arbiter;
   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pipe_we;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_wd;
   logic        pipe_stall;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_wd;
   logic        mdu_ready;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [4:0]  rs1, rs2;
   logic        rs1_busy, rs2_busy;
   logic        we3;
   logic [4:0]  a3;
   logic [31:0] wd3;

   always #5 clk = ~clk;

   rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .pipe_we_i(pipe_we), .pipe_rd_i(pipe_rd), .pipe_wd_i(pipe_wd), .pipe_stall_o(pipe_stall),
      .mdu_valid_i(mdu_valid), .mdu_rd_i(mdu_rd), .mdu_wd_i(mdu_wd), .mdu_ready_o(mdu_ready),
      .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
      .rs1_i(rs1), .rs2_i(rs2), .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
      .we3_o(we3), .a3_o(a3), .wd3_o(wd3)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] wd;
   } ent_t;

   ent_t mq[$];
   bit   pend[32];
   int   starve;
   bit   prev_stall;
   int   checks = 0;
   int   errors = 0;

   logic        last_we, last_stall, last_ready, last_b1;
   logic [4:0]  last_a3;
   logic [31:0] last_wd;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic idle();
      rst_n = 1'b1; pipe_we = 0; pipe_rd = 0; pipe_wd = 0;
      mdu_valid = 0; mdu_rd = 0; mdu_wd = 0;
      issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
   endtask

   // Called just after a rising edge with inputs applied; checks this cycle and advances the model.
   task automatic step();
      bit empty, mwin, e_we, e_stall, e_ready, e_b1, e_b2;
      logic [4:0]  e_a3;
      logic [31:0] e_wd;
      ent_t        ne;
      #2;
      empty = (mq.size() == 0);
      mwin = 0; e_we = 0; e_stall = 0; e_ready = 0; e_b1 = 0; e_b2 = 0;
      e_a3 = pipe_rd; e_wd = pipe_wd;
      if (rst_n) begin
         mwin    = !empty && (!pipe_we || starve == STARVE_MAX);
         e_stall = !empty && pipe_we && starve == STARVE_MAX;
         e_ready = mq.size() < DEPTH;
         if (mwin) begin
            e_a3 = mq[0].rd; e_wd = mq[0].wd; e_we = (mq[0].rd != 0);
         end else begin
            e_we = pipe_we && (pipe_rd != 0);
         end
         e_b1 = (rs1 != 0) && pend[rs1];
         e_b2 = (rs2 != 0) && pend[rs2];
         if (pipe_we && pipe_rd != 0 && pend[pipe_rd]) begin
            errors++;
            $display("FAIL waw_stimulus rd %0d is pending at %0t", pipe_rd, $time);
         end
         if (mdu_valid && !mdu_ready) begin
            errors++;
            $display("FAIL push_not_ready at %0t", $time);
         end
      end
      chk("we3", we3, e_we);
      chk("stall", pipe_stall, e_stall);
      chk("ready", mdu_ready, e_ready);
      chk("rs1_busy", rs1_busy, e_b1);
      chk("rs2_busy", rs2_busy, e_b2);
      if (rst_n) begin
         chk("a3", a3, e_a3);
         chk("wd3", wd3, e_wd);
      end
      last_we = we3; last_stall = pipe_stall; last_ready = mdu_ready;
      last_b1 = rs1_busy; last_a3 = a3; last_wd = wd3;
      prev_stall = e_stall;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         mq.delete();
         foreach (pend[i]) pend[i] = 0;
         starve = 0;
         prev_stall = 0;
      end else begin
         if (mwin) begin
            pend[mq[0].rd] = 0;
            void'(mq.pop_front());
         end
         if (mdu_valid && e_ready) begin
            ne.rd = mdu_rd; ne.wd = mdu_wd;
            mq.push_back(ne);
         end
         if (issue_valid && issue_rd != 0) pend[issue_rd] = 1;
         starve = (empty || mwin) ? 0 : starve + 1;
      end
   endtask

   initial begin
      idle();
      rst_n = 0; mdu_valid = 1; mdu_rd = 5'd4; mdu_wd = 32'h1234;
      mq.delete(); foreach (pend[i]) pend[i] = 0; starve = 0; prev_stall = 0;
      @(posedge clk); #1;
      // Reset hold with a pushing MDU
      for (int k = 0; k < 3; k++) begin
         step();
         chk("rst_ready", last_ready, 1'b0);
         chk("rst_we3", last_we, 1'b0);
      end
      idle(); step();
      chk("post_rst_empty_we3", last_we, 1'b0);

      // Idle drain
      idle(); issue_valid = 1; issue_rd = 5; step();
      idle(); mdu_valid = 1; mdu_rd = 5; mdu_wd = 32'hDEADBEEF; rs1 = 5; step();
      chk("drain_busy_pre", last_b1, 1'b1);
      idle(); rs1 = 5; step();
      chk("drain_we3", last_we, 1'b1);
      chk("drain_a3", last_a3, 5'd5);
      chk("drain_wd3", last_wd, 32'hDEADBEEF);
      chk("drain_busy_wr", last_b1, 1'b1);
      idle(); rs1 = 5; step();
      chk("drain_busy_after", last_b1, 1'b0);

      // Starvation limit
      idle(); pipe_we = 1; pipe_rd = 7; pipe_wd = 32'h77;
      mdu_valid = 1; mdu_rd = 3; mdu_wd = 32'h33; step();
      mdu_valid = 0;
      for (int k = 1; k <= 6; k++) begin
         step();
         chk("starve_a3", last_a3, (k == 5) ? 5'd3 : 5'd7);
         chk("starve_stall", last_stall, (k == 5) ? 1'b1 : 1'b0);
      end

      // Full FIFO and ordering
      idle(); pipe_we = 1; pipe_rd = 8; pipe_wd = 32'h88;
      mdu_valid = 1; mdu_rd = 10; mdu_wd = 32'h1; step();
      mdu_rd = 11; mdu_wd = 32'h2; step();
      mdu_valid = 0; step();
      chk("full_ready", last_ready, 1'b0);
      chk("full_pipe_a3", last_a3, 5'd8);
      pipe_we = 0; step();
      chk("full_pop1_wd", last_wd, 32'h1);
      chk("full_pop1_ready", last_ready, 1'b0);
      mdu_valid = 1; mdu_rd = 12; mdu_wd = 32'h3; step();
      chk("full_pop2_wd", last_wd, 32'h2);
      mdu_valid = 0; step();
      chk("full_pop3_wd", last_wd, 32'h3);
      idle(); step();

      // x0 handling
      idle(); pipe_we = 1; pipe_rd = 0; pipe_wd = 32'hAB; step();
      chk("x0_pipe_we3", last_we, 1'b0);
      chk("x0_pipe_wd3", last_wd, 32'hAB);
      idle(); mdu_valid = 1; mdu_rd = 0; mdu_wd = 32'hCD; step();
      idle(); step();
      chk("x0_mdu_we3", last_we, 1'b0);
      chk("x0_mdu_wd3", last_wd, 32'hCD);
      idle(); issue_valid = 1; issue_rd = 0; step();
      idle(); step();
      chk("x0_busy", last_b1, 1'b0);
      chk("x0_ready_after_pop", last_ready, 1'b1);

      // Set/clear collision
      idle(); issue_valid = 1; issue_rd = 9; step();
      idle(); mdu_valid = 1; mdu_rd = 9; mdu_wd = 32'h99; step();
      idle(); issue_valid = 1; issue_rd = 9; rs1 = 9; step();
      chk("coll_we3", last_we, 1'b1);
      chk("coll_a3", last_a3, 5'd9);
      idle(); rs1 = 9; step();
      chk("coll_busy", last_b1, 1'b1);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(0, 149) != 0);
         if (!prev_stall) begin
            pipe_we = ($urandom_range(0, 2) != 0);
            pipe_rd = 5'($urandom_range(0, 31));
            pipe_wd = $urandom;
            if (pipe_rd != 0 && pend[pipe_rd]) pipe_we = 0;
         end
         mdu_valid = ($urandom_range(0, 1) == 1) && (mq.size() < DEPTH);
         mdu_rd = 5'($urandom_range(0, 31));
         mdu_wd = $urandom;
         issue_valid = ($urandom_range(0, 3) == 0);
         issue_rd = 5'($urandom_range(0, 31));
         if (pipe_we && issue_rd == pipe_rd) issue_valid = 0;
         rs1 = 5'($urandom_range(0, 31));
         rs2 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the register file's single write port (we3/a3/wd3) and shares it between two writers: the in-order pipeline writeback and a long-latency multiply/divide unit (MDU).
- MDU results are buffered in a small FIFO and drained into idle write-port cycles.
- A starvation limit forces the pipeline to stall so buffered results can drain.
- A pending-destination scoreboard tells decode which source registers still await an MDU result.

Parameters:
DEPTH, 2, MDU result FIFO entries (power of 2, >=2)
STARVE_MAX, 4, consecutive cycles a non-empty FIFO may be blocked before a forced MDU write

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
pipe_we_i  in  1  pipeline writeback request
pipe_rd_i  in  5  pipeline destination register
pipe_wd_i  in  32  pipeline write data
pipe_stall_o  out  1  pipeline must hold its writeback stage this cycle
mdu_valid_i  in  1  MDU result valid
mdu_rd_i  in  5  MDU destination register
mdu_wd_i  in  32  MDU result data
mdu_ready_o  out  1  FIFO can accept an MDU result
issue_valid_i  in  1  MDU op issued; mark destination pending
issue_rd_i  in  5  destination of the issued MDU op
rs1_i, rs2_i  in  5 each  decode source registers
rs1_busy_o, rs2_busy_o  out  1 each  source awaits an MDU result
we3_o  out  1  register file write enable
a3_o  out  5  register file write address
wd3_o  out  32  register file write data

Behaviour:
- Clock and reset:
  - One clock, clk_i, rising edge for all state.
  - rst_ni is synchronous, active-low.
  - Reset clears the FIFO to empty, clears all 32 pending bits, and sets starve_cnt to 0.
  - While rst_ni=0: we3_o=0, pipe_stall_o=0, mdu_ready_o=0, busy outputs 0.
  - A reset mid-operation discards buffered MDU results. The MDU must also be flushed; that is the integrator's responsibility.
- Write-port outputs:
  - we3_o, a3_o and wd3_o are combinational from the current FIFO head and the pipe_* inputs.
  - The register file writes on the falling edge, so a granted write lands in the same cycle (zero added latency).
- FIFO:
  - mdu_ready_o = !full.
  - Push on mdu_valid_i && mdu_ready_o.
  - Pop when the MDU is granted.
  - Push and pop in the same cycle are allowed when not full. A push into an empty FIFO is not grantable until the next cycle (no bypass).
  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full and empty come from the pointer MSB/LSB compare.
- Grant each cycle:
  1. FIFO empty -> pipeline owns the port. we3_o=pipe_we_i, a3_o=pipe_rd_i, wd3_o=pipe_wd_i.
  2. FIFO non-empty and pipe_we_i=0 -> MDU head is written and popped.
  3. FIFO non-empty, pipe_we_i=1, starve_cnt<STARVE_MAX -> pipeline wins; starve_cnt increments.
  4. FIFO non-empty, pipe_we_i=1, starve_cnt==STARVE_MAX -> MDU head is written and popped; pipe_stall_o=1. The pipeline holds pipe_* stable and retries next cycle.
- starve_cnt:
  - Resets to 0 on any MDU pop or when the FIFO is empty.
  - Width is clog2(STARVE_MAX+1).
- pipe_stall_o is asserted only in case 4 and never in two consecutive cycles. After a forced pop, starve_cnt=0, so the pipeline wins next.
- x0 handling:
  - Whenever the selected destination is 0, we3_o is forced to 0; address and data still pass through.
  - An MDU entry with rd=0 is still accepted and popped.
  - Issue with rd=0 sets no pending bit.
- Scoreboard:
  - pending[r] is set at the clock edge when issue_valid_i && issue_rd_i==r (r!=0).
  - pending[r] is cleared at the edge when an MDU entry with rd=r is popped.
  - Simultaneous set and clear of the same r: set wins.
  - rsN_busy_o = pending[rsN_i], and 0 for rsN_i=0.
  - Combinational from the registered bits, so a clear is visible the cycle after the write.
- Hazards and illegal stimulus:
  - Decode stalls on busy sources and on a busy destination (WAW), so a pipeline write to a pending rd never occurs. The bench asserts this.
  - Pushing while not ready is ignored and is an assertion failure in the bench.

Test Plan:
- Reset hold: rst_ni=0 for 3 cycles with mdu_valid_i=1 -> mdu_ready_o=0, we3_o=0, FIFO stays empty.
- Idle drain: issue rd=5; push MDU (rd=5, 0xDEADBEEF) with pipe_we_i=0.
  - Next cycle: we3_o=1, a3_o=5, wd3_o=0xDEADBEEF.
  - rs1_i=5 gives busy=1 up to and including the write cycle, and 0 the cycle after.
- Pipeline priority and starvation: FIFO holds one entry; pipe_we_i=1 continuously (rd=7).
  - 4 pipeline writes.
  - 5th cycle: MDU write with pipe_stall_o=1.
  - 6th cycle: pipeline rd=7 write, pipe_stall_o=0.
- Full FIFO: push 2 results while pipe_we_i=1 -> mdu_ready_o=0 after the 2nd push.
  - A third push is held off until the first pop.
  - Data emerges in FIFO order (0x1, 0x2).
- x0 handling: pipe write rd=0 -> we3_o=0.
  - MDU entry rd=0 pops with we3_o=0.
  - issue rd=0 -> rs1_busy_o stays 0 for rs1_i=0.
- Set/clear collision: pending[9]=1; in one cycle the MDU entry rd=9 pops and issue_rd_i=9 -> pending[9] remains 1 afterwards.
